// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller and its
// register-match helper.
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2,
    FLUSH      = 2'd3
  } hz_state_e;

  localparam int unsigned REG_ZERO         = 0;
  localparam int unsigned LOAD_LAT_DEF     = 1;
  localparam int unsigned FLUSH_CYCLES_DEF = 1;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side bundle of the stall controller: hazard inputs from ID/EX/MEM
// and the write-enable / bubble / flush controls going back to the pipeline.
interface hazard_stall_ctrl_if #(
  parameter int REG_ADDR_W = 5
);
  logic                  IDEXMemRead;
  logic [REG_ADDR_W-1:0] IDEXRegisterRt;
  logic [REG_ADDR_W-1:0] IFIDRegisterRs;
  logic [REG_ADDR_W-1:0] IFIDRegisterRt;
  logic                  IFIDUsesRt;
  logic                  EXMEMMemAccess;
  logic                  dMemReady;
  logic                  redirect;
  logic                  PCWrite;
  logic                  IFIDWrite;
  logic                  IFIDFlush;
  logic                  IDEXBubble;
  logic                  pipeFreeze;
  logic                  busy;

  modport master (
    output IDEXMemRead, IDEXRegisterRt, IFIDRegisterRs, IFIDRegisterRt,
           IFIDUsesRt, EXMEMMemAccess, dMemReady, redirect,
    input  PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, pipeFreeze, busy
  );

  modport slave (
    input  IDEXMemRead, IDEXRegisterRt, IFIDRegisterRs, IFIDRegisterRt,
           IFIDUsesRt, EXMEMMemAccess, dMemReady, redirect,
    output PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, pipeFreeze, busy
  );
endinterface

// File: rtl/hazard_match.sv
// Combinational load-use comparator; register 0 never produces a hazard.
// Kept standalone so the forwarding unit can reuse it.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  i_mem_read,
  input  logic [REG_ADDR_W-1:0] i_ex_rt,
  input  logic [REG_ADDR_W-1:0] i_id_rs,
  input  logic [REG_ADDR_W-1:0] i_id_rt,
  input  logic                  i_uses_rt,
  output logic                  o_hit
);

  logic w_dst_nonzero;
  logic w_rs_match;
  logic w_rt_match;

  assign w_dst_nonzero = (i_ex_rt != REG_ADDR_W'(REG_ZERO));
  assign w_rs_match    = (i_ex_rt == i_id_rs);
  assign w_rt_match    = i_uses_rt && (i_ex_rt == i_id_rt);
  assign o_hit         = i_mem_read && w_dst_nonzero && (w_rs_match || w_rt_match);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the 5-stage pipeline. Optional performance
// counters are compiled in with HAZARD_PERF_CNT_EN.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int LOAD_LAT     = LOAD_LAT_DEF,
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter int CNT_W        = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  hazard_stall_ctrl_if.slave  bus
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]         loadStallCnt,
  output logic [31:0]         memWaitCnt,
  output logic [31:0]         flushCnt
`endif
);

  hz_state_e        r_state;
  hz_state_e        r_resume;
  logic [CNT_W-1:0] r_cnt;

  hz_state_e        w_state_nxt;
  hz_state_e        w_resume_nxt;
  hz_state_e        w_eff_state;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_dec;
  logic             w_cnt_last;
  logic             w_lu_hit;
  logic             w_mem_wait;
  logic             w_pc_write;
  logic             w_ifid_write;
  logic             w_ifid_flush;
  logic             w_idex_bubble;
  logic             w_freeze;
  logic             w_ls_cycle;

  hazard_match #(.REG_ADDR_W(REG_ADDR_W)) u_match (
    .i_mem_read (bus.IDEXMemRead),
    .i_ex_rt    (bus.IDEXRegisterRt),
    .i_id_rs    (bus.IFIDRegisterRs),
    .i_id_rt    (bus.IFIDRegisterRt),
    .i_uses_rt  (bus.IFIDUsesRt),
    .o_hit      (w_lu_hit)
  );

  assign w_mem_wait = bus.EXMEMMemAccess && !bus.dMemReady;
  // The memory-ready cycle behaves exactly like the state that was interrupted.
  assign w_eff_state = (r_state == MEM_WAIT) ? r_resume : r_state;
  assign w_cnt_dec   = (r_cnt == CNT_W'(0)) ? CNT_W'(0) : (r_cnt - CNT_W'(1));
  assign w_cnt_last  = (r_cnt <= CNT_W'(1));

  // Next-state, counter and control outputs; memWait > redirect > luHit.
  always_comb begin
    w_state_nxt   = r_state;
    w_resume_nxt  = r_resume;
    w_cnt_nxt     = r_cnt;
    w_pc_write    = 1'b1;
    w_ifid_write  = 1'b1;
    w_ifid_flush  = 1'b0;
    w_idex_bubble = 1'b0;
    w_freeze      = 1'b0;
    w_ls_cycle    = 1'b0;
    if (w_mem_wait) begin
      w_pc_write   = 1'b0;
      w_ifid_write = 1'b0;
      w_freeze     = 1'b1;
      w_state_nxt  = MEM_WAIT;
      if (r_state != MEM_WAIT) begin
        w_resume_nxt = r_state;
      end else begin
        w_resume_nxt = r_resume;
      end
    end else if (bus.redirect) begin
      w_ifid_flush  = 1'b1;
      w_idex_bubble = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        w_cnt_nxt   = CNT_W'(FLUSH_CYCLES - 1);
        w_state_nxt = FLUSH;
      end else begin
        w_cnt_nxt   = CNT_W'(0);
        w_state_nxt = IDLE;
      end
    end else begin
      case (w_eff_state)
        LOAD_STALL: begin
          w_pc_write    = 1'b0;
          w_ifid_write  = 1'b0;
          w_idex_bubble = 1'b1;
          w_ls_cycle    = 1'b1;
          w_cnt_nxt     = w_cnt_dec;
          w_state_nxt   = w_cnt_last ? IDLE : LOAD_STALL;
        end
        FLUSH: begin
          w_ifid_flush = 1'b1;
          w_cnt_nxt    = w_cnt_dec;
          w_state_nxt  = w_cnt_last ? IDLE : FLUSH;
        end
        IDLE: begin
          if (w_lu_hit) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_bubble = 1'b1;
            w_ls_cycle    = 1'b1;
            if (LOAD_LAT > 1) begin
              w_cnt_nxt   = CNT_W'(LOAD_LAT - 1);
              w_state_nxt = LOAD_STALL;
            end else begin
              w_state_nxt = IDLE;
            end
          end else begin
            w_state_nxt = IDLE;
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // State, resume-state and down-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_resume <= IDLE;
      r_cnt    <= CNT_W'(0);
    end else begin
      r_state  <= w_state_nxt;
      r_resume <= w_resume_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  // Outputs snap to their idle values the moment reset is asserted.
  assign bus.PCWrite    = rst_n ? w_pc_write    : 1'b1;
  assign bus.IFIDWrite  = rst_n ? w_ifid_write  : 1'b1;
  assign bus.IFIDFlush  = rst_n ? w_ifid_flush  : 1'b0;
  assign bus.IDEXBubble = rst_n ? w_idex_bubble : 1'b0;
  assign bus.pipeFreeze = rst_n ? w_freeze      : 1'b0;
  assign bus.busy       = rst_n && (r_state != IDLE);

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_ls_cnt;
  logic [31:0] r_mw_cnt;
  logic [31:0] r_fl_cnt;

  // Event counters; only the memWait counter advances while frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ls_cnt <= 32'd0;
      r_mw_cnt <= 32'd0;
      r_fl_cnt <= 32'd0;
    end else begin
      if (w_mem_wait) begin
        r_mw_cnt <= r_mw_cnt + 32'd1;
      end else begin
        r_mw_cnt <= r_mw_cnt;
      end
      if (!w_freeze && w_ls_cycle) begin
        r_ls_cnt <= r_ls_cnt + 32'd1;
      end else begin
        r_ls_cnt <= r_ls_cnt;
      end
      if (!w_freeze && w_ifid_flush) begin
        r_fl_cnt <= r_fl_cnt + 32'd1;
      end else begin
        r_fl_cnt <= r_fl_cnt;
      end
    end
  end

  assign loadStallCnt = r_ls_cnt;
  assign memWaitCnt   = r_mw_cnt;
  assign flushCnt     = r_fl_cnt;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Cycle-by-cycle vector bench for hazard_stall_ctrl with LOAD_LAT = 2 and
// FLUSH_CYCLES = 2; perf counters are checked when HAZARD_PERF_CNT_EN is set.
module tb_hazard_stall_ctrl;

  typedef struct {
    logic       rstn;
    logic       rd;
    logic [4:0] ert;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urt;
    logic       acc;
    logic       rdy;
    logic       redir;
    logic [5:0] exp;
  } vec_t;

  logic clk;
  logic rst_n;
  vec_t tbl[$];
  logic [5:0] sb[$];
  int checks;
  int errors;

  hazard_stall_ctrl_if #(.REG_ADDR_W(5)) bus ();

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] loadStallCnt;
  logic [31:0] memWaitCnt;
  logic [31:0] flushCnt;
`endif

  hazard_stall_ctrl #(
    .REG_ADDR_W   (5),
    .LOAD_LAT     (2),
    .FLUSH_CYCLES (2),
    .CNT_W        (3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .loadStallCnt (loadStallCnt),
    .memWaitCnt   (memWaitCnt),
    .flushCnt     (flushCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // exp = {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, pipeFreeze, busy}
  task automatic add(input logic rstn, input logic rd, input logic [4:0] ert,
                     input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                     input logic acc, input logic rdy, input logic redir,
                     input logic [5:0] exp);
    vec_t v;
    v.rstn = rstn; v.rd = rd; v.ert = ert; v.rs = rs; v.rt = rt; v.urt = urt;
    v.acc = acc; v.rdy = rdy; v.redir = redir; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    rst_n              = v.rstn;
    bus.IDEXMemRead    = v.rd;
    bus.IDEXRegisterRt = v.ert;
    bus.IFIDRegisterRs = v.rs;
    bus.IFIDRegisterRt = v.rt;
    bus.IFIDUsesRt     = v.urt;
    bus.EXMEMMemAccess = v.acc;
    bus.dMemReady      = v.rdy;
    bus.redirect       = v.redir;
  endtask

  initial begin
    logic [5:0] got;
    logic [5:0] want;
    int exp_ls;
    int exp_mw;
    int exp_fl;
    checks = 0;
    errors = 0;
    exp_ls = 0;
    exp_mw = 0;
    exp_fl = 0;
    rst_n = 1'b0;
    bus.IDEXMemRead = 1'b0; bus.IDEXRegisterRt = 5'd0; bus.IFIDRegisterRs = 5'd0;
    bus.IFIDRegisterRt = 5'd0; bus.IFIDUsesRt = 1'b0; bus.EXMEMMemAccess = 1'b0;
    bus.dMemReady = 1'b0; bus.redirect = 1'b0;

    //  rstn rd   ert    rs     rt    urt  acc  rdy  redir  expected
    add(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b110000); // reset
    add(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b110000); // idle
    add(1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000100); // load-use $8 Rs
    add(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000101); // 2nd stall cycle
    add(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b110000); // released
    add(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b110000); // $0 never hazards
    add(1'b1, 1'b1, 5'd9, 5'd3, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 6'b110000); // Rt unused
    add(1'b1, 1'b1, 5'd9, 5'd3, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000100); // Rt used
    add(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 6'b000011); // memWait in LS
    add(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 6'b000011); // memWait beats redirect
    add(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 6'b000011); // 3rd frozen
    add(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 6'b000101); // resume LS
    add(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b110000); // idle
    add(1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 6'b111100); // redirect + luHit
    add(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b111001); // FLUSH
    add(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b110000); // idle
    add(1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 6'b000010); // memWait beats luHit
    add(1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 6'b000101); // ready, luHit now
    add(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000101); // LS
    add(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b110000); // idle
    add(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 6'b111100); // redirect
    add(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b110000); // reset mid-FLUSH
    add(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b110000); // IDLE after release
    add(1'b1, 1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000100); // load-use $7
    add(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 6'b111101); // redirect cancels LS
    add(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 6'b111101); // redirect reloads
    add(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b111001); // last FLUSH
    add(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b110000); // idle
    add(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 6'b111100); // redirect
    add(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 6'b000011); // memWait in FLUSH
    add(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 6'b111001); // resume FLUSH
    add(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b110000); // idle

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      drive(tbl[i]);
      sb.push_back(tbl[i].exp);
      if (!tbl[i].rstn) begin
        exp_ls = 0; exp_mw = 0; exp_fl = 0;
      end else begin
        if (tbl[i].exp[2] && !tbl[i].exp[3]) exp_ls++;
        if (tbl[i].exp[1]) exp_mw++;
        if (tbl[i].exp[3]) exp_fl++;
      end
      #3;
      got  = {bus.PCWrite, bus.IFIDWrite, bus.IFIDFlush, bus.IDEXBubble, bus.pipeFreeze, bus.busy};
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL row%0d: got {pcw,ifw,fl,bub,frz,busy}=%b expected %b", i, got, want);
      end
    end

`ifdef HAZARD_PERF_CNT_EN
    @(posedge clk);
    #1;
    checks++;
    if (loadStallCnt !== 32'(exp_ls)) begin
      errors++;
      $display("FAIL loadStallCnt: got %0d expected %0d", loadStallCnt, exp_ls);
    end
    checks++;
    if (memWaitCnt !== 32'(exp_mw)) begin
      errors++;
      $display("FAIL memWaitCnt: got %0d expected %0d", memWaitCnt, exp_mw);
    end
    checks++;
    if (flushCnt !== 32'(exp_fl)) begin
      errors++;
      $display("FAIL flushCnt: got %0d expected %0d", flushCnt, exp_fl);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
